posmap_walk_ctrl: RTL and testbench

- Initiator that drives the PosMap/PLB lookup interface (the PPP responder) on behalf of the frontend.
- For one program access it walks PosMap recursion levels upward with Read lookups until a hit.
- It then walks back down. At each level it issues an update Write, a backend fetch, and a Refill or InitRefill of the next-lower level, writing back any evicted PLB block.
- It sits between the frontend request port, the PPP command/response port and the backend access port.

---
 rtl/posmap_walk_ctrl_if.sv | 67 ++++++
 rtl/posmap_walk_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_posmap_walk_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/posmap_walk_ctrl_if.sv
// Channel bundle between posmap_walk_ctrl (master) and its frontend, PPP and backend
// neighbours (slave side).
interface posmap_walk_ctrl_if #(
    parameter int ORAMU = 32,
    parameter int ORAML = 20
);
    localparam int LeafWidth = ORAML + 1;

    logic                 ReqValid;
    logic                 ReqReady;
    logic [ORAMU-1:0]     ReqAddr;
    logic                 ReqDone;

    logic                 PPPCmdValid;
    logic                 PPPCmdReady;
    logic [1:0]           PPPCmd;
    logic [ORAMU-1:0]     PPPAddr;
    logic                 PPPDInValid;
    logic [LeafWidth-1:0] PPPDIn;
    logic                 PPPRefillDataReady;
    logic                 PPPValid;
    logic                 PPPOutReady;
    logic                 PPPHit;
    logic                 PPPUnInit;
    logic                 PPPEvict;
    logic [ORAML-1:0]     PPPOldLeaf;
    logic [ORAML-1:0]     PPPNewLeaf;
    logic [ORAMU-1:0]     PPPAddrOut;
    logic                 PPPEvictValid;
    logic [LeafWidth-1:0] PPPEvictData;

    logic                 BeReqValid;
    logic                 BeReqReady;
    logic [ORAMU-1:0]     BeAddr;
    logic [ORAML-1:0]     BeOldLeaf;
    logic [ORAML-1:0]     BeNewLeaf;
    logic                 BeUnInit;
    logic                 BeDataValid;
    logic [LeafWidth-1:0] BeData;
    logic                 BeWbValid;
    logic                 BeWbReady;
    logic [ORAMU-1:0]     BeWbAddr;
    logic [ORAML-1:0]     BeWbLeaf;
    logic [LeafWidth-1:0] BeWbData;

    modport master (
        input  ReqValid, ReqAddr,
        output ReqReady, ReqDone,
        output PPPCmdValid, PPPCmd, PPPAddr, PPPDInValid, PPPDIn, PPPOutReady,
        input  PPPCmdReady, PPPRefillDataReady, PPPValid, PPPHit, PPPUnInit, PPPEvict,
        input  PPPOldLeaf, PPPNewLeaf, PPPAddrOut, PPPEvictValid, PPPEvictData,
        output BeReqValid, BeAddr, BeOldLeaf, BeNewLeaf, BeUnInit,
        input  BeReqReady, BeDataValid, BeData, BeWbReady,
        output BeWbValid, BeWbAddr, BeWbLeaf, BeWbData
    );

    modport slave (
        output ReqValid, ReqAddr,
        input  ReqReady, ReqDone,
        input  PPPCmdValid, PPPCmd, PPPAddr, PPPDInValid, PPPDIn, PPPOutReady,
        output PPPCmdReady, PPPRefillDataReady, PPPValid, PPPHit, PPPUnInit, PPPEvict,
        output PPPOldLeaf, PPPNewLeaf, PPPAddrOut, PPPEvictValid, PPPEvictData,
        input  BeReqValid, BeAddr, BeOldLeaf, BeNewLeaf, BeUnInit,
        output BeReqReady, BeDataValid, BeData, BeWbReady,
        input  BeWbValid, BeWbAddr, BeWbLeaf, BeWbData
    );
endinterface

// File: rtl/posmap_walk_ctrl.sv
// PosMap recursion walker: Read lookups upward until a PLB hit, then per level an update
// Write, a backend fetch and a (Init)Refill of the next-lower level with eviction writeback.
module posmap_walk_ctrl #(
    parameter int          ORAMU          = 32,
    parameter int          ORAML          = 20,
    parameter int          LogLeafInBlock = 4,
    parameter int          NumLevels      = 3,
    parameter logic [31:0] LevelStride    = 32'h4000_0000
) (
    input logic                clk_i,
    input logic                rst_ni,
    posmap_walk_ctrl_if.master walk
);
    localparam int LeafWidth = ORAML + 1;
    localparam int BlkLeaves = 1 << LogLeafInBlock;
    localparam int LW        = $clog2(NumLevels + 1);
    localparam int PW        = LogLeafInBlock;

    localparam logic [LW-1:0] LV_ONE   = LW'(1);
    localparam logic [LW-1:0] LV_TOP   = LW'(NumLevels);
    localparam logic [PW-1:0] PTR_LAST = PW'(BlkLeaves - 1);

    localparam logic [1:0] CMD_WRITE  = 2'b00;
    localparam logic [1:0] CMD_READ   = 2'b01;
    localparam logic [1:0] CMD_REFILL = 2'b10;
    localparam logic [1:0] CMD_INIT   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_LOOKUP, S_L_WAIT, S_UPD, S_U_WAIT, S_BE_REQ,
        S_BE_DATA, S_REFILL, S_R_STREAM, S_R_WAIT, S_EVICT_WB
    } state_e;

    function automatic logic [ORAMU-1:0] lv_addr(input logic [LW-1:0] k,
                                                 input logic [ORAMU-1:0] a);
        logic [31:0] base;
        base = 32'(k) * LevelStride;
        return ORAMU'(base) + (a >> (int'(k) * LogLeafInBlock));
    endfunction

    function automatic logic [ORAMU-1:0] blk_addr(input logic [ORAMU-1:0] a);
        return {a[ORAMU-1:PW], PW'(0)};
    endfunction

    state_e               state_q;
    logic [LW-1:0]        lvl_q;
    logic [ORAMU-1:0]     addr_q;
    logic [ORAML-1:0]     old_leaf_q, new_leaf_q;
    logic                 uninit_q;
    logic [PW-1:0]        rptr_q, eptr_q, wptr_q;
    logic                 evict_full_q;
    logic                 req_ready_q, req_done_q;
    logic                 cmd_valid_q, out_ready_q;
    logic [1:0]           cmd_q;
    logic [ORAMU-1:0]     cmd_addr_q;
    logic                 be_valid_q;
    logic [ORAMU-1:0]     be_addr_q;
    logic                 wb_valid_q;
    logic [ORAMU-1:0]     wb_addr_q;
    logic [ORAML-1:0]     wb_leaf_q;
    logic [LeafWidth-1:0] refill_buf [BlkLeaves];
    logic [LeafWidth-1:0] evict_buf  [BlkLeaves];

    logic [ORAMU-1:0] cur_addr, up_addr, low_addr, low_blk;
    logic             rsp, evict_cap, refill_cap;

    assign cur_addr   = lv_addr(lvl_q, addr_q);
    assign up_addr    = lv_addr(lvl_q + LV_ONE, addr_q);
    assign low_addr   = lv_addr(lvl_q - LV_ONE, addr_q);
    assign low_blk    = blk_addr(low_addr);
    assign rsp        = walk.PPPValid && out_ready_q;
    assign evict_cap  = (state_q == S_R_STREAM || state_q == S_R_WAIT) && walk.PPPEvictValid;
    assign refill_cap = (state_q == S_BE_DATA) && walk.BeDataValid;

    task automatic issue(input logic [1:0] c, input logic [ORAMU-1:0] a);
        cmd_valid_q <= 1'b1;
        cmd_q       <= c;
        cmd_addr_q  <= a;
    endtask

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            lvl_q        <= '0;
            addr_q       <= '0;
            old_leaf_q   <= '0;
            new_leaf_q   <= '0;
            uninit_q     <= 1'b0;
            rptr_q       <= '0;
            eptr_q       <= '0;
            wptr_q       <= '0;
            evict_full_q <= 1'b0;
            req_ready_q  <= 1'b1;
            req_done_q   <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_q        <= CMD_READ;
            cmd_addr_q   <= '0;
            out_ready_q  <= 1'b0;
            be_valid_q   <= 1'b0;
            be_addr_q    <= '0;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_leaf_q    <= '0;
        end else begin
            req_done_q <= 1'b0;
            if (evict_cap) begin
                eptr_q <= eptr_q + 1'b1;
                if (eptr_q == PTR_LAST) evict_full_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: if (walk.ReqValid) begin
                    addr_q      <= walk.ReqAddr;
                    lvl_q       <= LV_ONE;
                    req_ready_q <= 1'b0;
                    issue(CMD_READ, lv_addr(LV_ONE, walk.ReqAddr));
                    state_q     <= S_LOOKUP;
                end
                S_LOOKUP, S_UPD: if (walk.PPPCmdReady) begin
                    cmd_valid_q <= 1'b0;
                    out_ready_q <= 1'b1;
                    state_q     <= (state_q == S_LOOKUP) ? S_L_WAIT : S_U_WAIT;
                end
                S_L_WAIT: if (rsp) begin
                    out_ready_q <= 1'b0;
                    if (walk.PPPHit) begin
                        issue(CMD_WRITE, cur_addr);
                        state_q <= S_UPD;
                    end else begin
                        lvl_q   <= lvl_q + LV_ONE;
                        issue(CMD_READ, up_addr);
                        state_q <= S_LOOKUP;
                    end
                end
                S_U_WAIT: if (rsp) begin
                    out_ready_q <= 1'b0;
                    old_leaf_q  <= walk.PPPOldLeaf;
                    new_leaf_q  <= walk.PPPNewLeaf;
                    uninit_q    <= walk.PPPUnInit;
                    be_valid_q  <= 1'b1;
                    be_addr_q   <= (lvl_q == LV_ONE) ? addr_q : low_blk;
                    state_q     <= S_BE_REQ;
                end
                S_BE_REQ: if (walk.BeReqReady) begin
                    be_valid_q <= 1'b0;
                    if (lvl_q == LV_ONE) begin
                        req_done_q  <= 1'b1;
                        req_ready_q <= 1'b1;
                        lvl_q       <= '0;
                        state_q     <= S_IDLE;
                    end else if (uninit_q) begin
                        issue(CMD_INIT, low_blk);
                        state_q <= S_REFILL;
                    end else begin
                        rptr_q  <= '0;
                        state_q <= S_BE_DATA;
                    end
                end
                S_BE_DATA: if (walk.BeDataValid) begin
                    rptr_q <= rptr_q + 1'b1;
                    if (rptr_q == PTR_LAST) begin
                        issue(CMD_REFILL, low_blk);
                        state_q <= S_REFILL;
                    end
                end
                S_REFILL: if (walk.PPPCmdReady) begin
                    cmd_valid_q  <= 1'b0;
                    rptr_q       <= '0;
                    eptr_q       <= '0;
                    evict_full_q <= 1'b0;
                    state_q      <= S_R_STREAM;
                end
                S_R_STREAM: if (walk.PPPRefillDataReady) begin
                    rptr_q <= rptr_q + 1'b1;
                    if (rptr_q == PTR_LAST) begin
                        out_ready_q <= 1'b1;
                        state_q     <= S_R_WAIT;
                    end
                end
                S_R_WAIT: if (rsp) begin
                    out_ready_q <= 1'b0;
                    if (walk.PPPEvict) begin
                        wb_addr_q  <= walk.PPPAddrOut;
                        wb_leaf_q  <= walk.PPPNewLeaf;
                        wptr_q     <= '0;
                        wb_valid_q <= 1'b1;
                        state_q    <= S_EVICT_WB;
                    end else begin
                        lvl_q   <= lvl_q - LV_ONE;
                        issue(CMD_WRITE, low_addr);
                        state_q <= S_UPD;
                    end
                end
                S_EVICT_WB: if (walk.BeWbReady) begin
                    wptr_q <= wptr_q + 1'b1;
                    if (wptr_q == PTR_LAST) begin
                        wb_valid_q <= 1'b0;
                        lvl_q      <= lvl_q - LV_ONE;
                        issue(CMD_WRITE, low_addr);
                        state_q    <= S_UPD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Block buffers hold payload only and need no reset.
    always_ff @(posedge clk_i) begin
        if (refill_cap) refill_buf[rptr_q] <= walk.BeData;
        if (evict_cap)  evict_buf[eptr_q]  <= walk.PPPEvictData;
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni && rsp) begin
            if (state_q == S_L_WAIT)
                assert (walk.PPPHit || lvl_q != LV_TOP)
                    else $fatal(1, "posmap_walk_ctrl: lookup missed at on-chip PosMap level");
            if (state_q == S_U_WAIT)
                assert (walk.PPPHit)
                    else $fatal(1, "posmap_walk_ctrl: update Write response without hit");
            if (state_q == S_R_WAIT && walk.PPPEvict)
                assert (evict_full_q || (walk.PPPEvictValid && eptr_q == PTR_LAST))
                    else $fatal(1, "posmap_walk_ctrl: refill response before full evicted block");
        end
    end
`endif

    assign walk.ReqReady    = req_ready_q;
    assign walk.ReqDone     = req_done_q;
    assign walk.PPPCmdValid = cmd_valid_q;
    assign walk.PPPCmd      = cmd_q;
    assign walk.PPPAddr     = cmd_addr_q;
    assign walk.PPPOutReady = out_ready_q;
    // Refill words follow the responder's ready in the same cycle so the index never skips.
    assign walk.PPPDInValid = (state_q == S_R_STREAM) && walk.PPPRefillDataReady;
    assign walk.PPPDIn      = (walk.PPPDInValid && !uninit_q) ? refill_buf[rptr_q] : '0;
    assign walk.BeReqValid  = be_valid_q;
    assign walk.BeAddr      = be_addr_q;
    assign walk.BeOldLeaf   = old_leaf_q;
    assign walk.BeNewLeaf   = new_leaf_q;
    assign walk.BeUnInit    = uninit_q;
    assign walk.BeWbValid   = wb_valid_q;
    assign walk.BeWbAddr    = wb_addr_q;
    assign walk.BeWbLeaf    = wb_leaf_q;
    assign walk.BeWbData    = evict_buf[wptr_q];
endmodule

// File: tb/tb_posmap_walk_ctrl.sv
// Directed and randomized walks against a transaction-level model of the PosMap walk.
module tb_posmap_walk_ctrl;
    localparam int TMO = 200;
    localparam logic [1:0] C_WRITE = 2'b00, C_READ = 2'b01, C_REFILL = 2'b10, C_INIT = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    posmap_walk_ctrl_if #(.ORAMU(32), .ORAML(20)) bus ();

    posmap_walk_ctrl #(
        .ORAMU(32), .ORAML(20), .LogLeafInBlock(4), .NumLevels(3), .LevelStride(32'h4000_0000)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .walk  (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_write = 0, n_refill = 0, n_done = 0;
    logic [31:0] ev_addr_cfg;
    logic [19:0] ev_leaf_cfg;

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.PPPCmdValid && bus.PPPCmdReady && bus.PPPCmd == C_WRITE) n_write <= n_write + 1;
            if (bus.PPPCmdValid && bus.PPPCmdReady && bus.PPPCmd[1]) n_refill <= n_refill + 1;
            if (bus.ReqDone) n_done <= n_done + 1;
        end
    end

    // Model: level k entry of address a lives at k*stride + a/16^k; blocks are 16-aligned.
    function automatic logic [31:0] m_lv(input int k, input logic [31:0] a);
        return 32'(k) * 32'h4000_0000 + (a >> (4 * k));
    endfunction

    function automatic logic [31:0] m_blk(input logic [31:0] a);
        return a & ~32'hF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.PPPCmdValid;
            1:       return bus.PPPOutReady;
            2:       return bus.BeReqValid;
            default: return bus.ReqReady;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string tag);
        int n = 0;
        while (!sig(which)) begin
            if (n == TMO) begin
                checks++;
                errors++;
                $display("FAIL %s timeout observed=0 expected=1", tag);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic expect_cmd(input logic [1:0] c, input logic [31:0] a, input int delay, input string tag);
        wait_sig(0, tag);
        for (int d = 0; d < delay; d++) begin
            bus.PPPCmdReady = 1'b0;
            check({tag, "_hold_valid"}, bus.PPPCmdValid, 1'b1);
            check({tag, "_hold"}, {bus.PPPCmd, bus.PPPAddr}, {c, a});
            @(negedge clk);
        end
        check({tag, "_cmd"}, bus.PPPCmd, c);
        check({tag, "_addr"}, bus.PPPAddr, a);
        bus.PPPCmdReady = 1'b1;
        @(negedge clk);
        bus.PPPCmdReady = 1'b0;
    endtask

    task automatic respond(input bit hit, input bit uninit, input bit evict,
                           input logic [19:0] oldl, input logic [19:0] newl, input logic [31:0] aout);
        wait_sig(1, "out_ready");
        bus.PPPValid   = 1'b1;
        bus.PPPHit     = hit;
        bus.PPPUnInit  = uninit;
        bus.PPPEvict   = evict;
        bus.PPPOldLeaf = oldl;
        bus.PPPNewLeaf = newl;
        bus.PPPAddrOut = aout;
        @(negedge clk);
        bus.PPPValid   = 1'b0;
    endtask

    task automatic run_walk(input logic [31:0] a, input int hit_lvl, input logic [3:0] uninit_m,
                            input logic [3:0] evict_m, input int delay, input bit gaps,
                            input bit wb_toggle, input int abort_word);
        logic [20:0] fetched [16];
        logic [20:0] ev [16];
        logic [19:0] oldl, newl;
        int w0, r0, d0, idx, j, n, beat;
        bit r;
        w0 = n_write; r0 = n_refill; d0 = n_done;
        wait_sig(3, "req_ready");
        bus.ReqValid = 1'b1;
        bus.ReqAddr  = a;
        @(negedge clk);
        bus.ReqValid = 1'b0;
        for (int k = 1; k <= hit_lvl; k++) begin
            expect_cmd(C_READ, m_lv(k, a), delay, "read");
            respond(k == hit_lvl, 1'b0, 1'b0, '0, '0, '0);
        end
        for (int l = hit_lvl; l >= 1; l--) begin
            oldl = 20'($urandom);
            newl = 20'($urandom);
            expect_cmd(C_WRITE, m_lv(l, a), delay, "write");
            respond(1'b1, uninit_m[l], 1'b0, oldl, newl, '0);
            wait_sig(2, "be_req");
            check("be_addr", bus.BeAddr, (l > 1) ? m_blk(m_lv(l - 1, a)) : a);
            check("be_old", bus.BeOldLeaf, oldl);
            check("be_new", bus.BeNewLeaf, newl);
            check("be_uninit", bus.BeUnInit, uninit_m[l]);
            check("be_no_wb", bus.BeWbValid, 1'b0);
            bus.BeReqReady = 1'b1;
            @(negedge clk);
            bus.BeReqReady = 1'b0;
            if (l == 1) break;
            for (int i = 0; i < 16; i++) begin
                fetched[i] = uninit_m[l] ? 21'h0 : 21'($urandom);
                ev[i]      = 21'($urandom);
            end
            if (!uninit_m[l]) begin
                for (int i = 0; i < 16; i++) begin
                    bus.BeDataValid = 1'b1;
                    bus.BeData      = fetched[i];
                    @(negedge clk);
                end
                bus.BeDataValid = 1'b0;
            end
            expect_cmd(uninit_m[l] ? C_INIT : C_REFILL, m_blk(m_lv(l - 1, a)), delay, "refill");
            idx = 0; j = 0; n = 0;
            while (idx < 16 && n < TMO) begin
                if (idx == abort_word) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_req_ready", bus.ReqReady, 1'b1);
                    check("rst_cmd_valid", bus.PPPCmdValid, 1'b0);
                    check("rst_din_valid", bus.PPPDInValid, 1'b0);
                    check("rst_out_ready", bus.PPPOutReady, 1'b0);
                    check("rst_be_valids", {bus.BeReqValid, bus.BeWbValid, bus.ReqDone}, 3'b000);
                    bus.PPPRefillDataReady = 1'b0;
                    bus.PPPEvictValid = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                    return;
                end
                r = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.PPPRefillDataReady = r;
                bus.PPPEvictValid = evict_m[l] && (j < 16);
                bus.PPPEvictData  = ev[j % 16];
                #1;
                check("din_valid", bus.PPPDInValid, r);
                if (r) begin
                    check("din_word", bus.PPPDIn, fetched[idx]);
                    idx++;
                end
                if (bus.PPPEvictValid) j++;
                @(negedge clk);
                n++;
            end
            bus.PPPRefillDataReady = 1'b0;
            bus.PPPEvictValid = 1'b0;
            check("din_count", idx, 16);
            respond(1'b1, 1'b0, evict_m[l], '0, ev_leaf_cfg, ev_addr_cfg);
            if (evict_m[l]) begin
                beat = 0; n = 0;
                while (beat < 16 && n < TMO) begin
                    bus.BeWbReady = wb_toggle ? (n % 2 == 0) : 1'b1;
                    #1;
                    check("wb_no_bereq", bus.BeReqValid, 1'b0);
                    if (bus.BeWbValid && bus.BeWbReady) begin
                        check("wb_addr", bus.BeWbAddr, ev_addr_cfg);
                        check("wb_leaf", bus.BeWbLeaf, ev_leaf_cfg);
                        check("wb_data", bus.BeWbData, ev[beat]);
                        beat++;
                    end
                    @(negedge clk);
                    n++;
                end
                bus.BeWbReady = 1'b0;
                check("wb_count", beat, 16);
            end
        end
        repeat (2) @(negedge clk);
        check("n_writes", n_write - w0, hit_lvl);
        check("n_refills", n_refill - r0, hit_lvl - 1);
        check("n_done", n_done - d0, 1);
        check("end_ready", bus.ReqReady, 1'b1);
        check("end_cmd_idle", bus.PPPCmdValid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ReqValid = 1'b0; bus.ReqAddr = '0;
        bus.PPPCmdReady = 1'b0; bus.PPPRefillDataReady = 1'b0; bus.PPPValid = 1'b0;
        bus.PPPHit = 1'b0; bus.PPPUnInit = 1'b0; bus.PPPEvict = 1'b0;
        bus.PPPOldLeaf = '0; bus.PPPNewLeaf = '0; bus.PPPAddrOut = '0;
        bus.PPPEvictValid = 1'b0; bus.PPPEvictData = '0;
        bus.BeReqReady = 1'b0; bus.BeDataValid = 1'b0; bus.BeData = '0; bus.BeWbReady = 1'b0;
        ev_addr_cfg = '0; ev_leaf_cfg = '0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", bus.ReqReady, 1'b1);
        check("reset_valids", {bus.PPPCmdValid, bus.PPPDInValid, bus.BeReqValid, bus.BeWbValid}, 4'b0000);
        check("reset_done_outrdy", {bus.ReqDone, bus.PPPOutReady}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        run_walk(32'h0000_0035, 1, 4'b0000, 4'b0000, 0, 1'b0, 1'b0, -1);
        run_walk(32'h0000_0035, 3, 4'b0000, 4'b0000, 0, 1'b0, 1'b0, -1);
        run_walk(32'h0000_0035, 2, 4'b0100, 4'b0000, 0, 1'b0, 1'b0, -1);
        ev_addr_cfg = 32'h4000_0120;
        ev_leaf_cfg = 20'h05A5A;
        run_walk(32'h0000_0035, 2, 4'b0000, 4'b0100, 0, 1'b0, 1'b1, -1);
        run_walk(32'h1234_5678, 3, 4'b0000, 4'b0000, 10, 1'b1, 1'b0, -1);
        run_walk(32'h0000_0035, 2, 4'b0000, 4'b0000, 0, 1'b0, 1'b0, 7);
        run_walk(32'h0000_0035, 1, 4'b0000, 4'b0000, 0, 1'b0, 1'b0, -1);

        for (int t = 0; t < 8; t++) begin
            ev_addr_cfg = $urandom;
            ev_leaf_cfg = 20'($urandom);
            run_walk($urandom, $urandom_range(1, 3), 4'($urandom) & 4'b1110, 4'($urandom) & 4'b1100,
                     $urandom_range(0, 3), 1'($urandom), 1'($urandom), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
